// File: rtl/config_write_arbiter.sv
// Arbitrates the eFPGA self-write config port between USB and JTAG, one owner per session.
// Latency: one cycle from an accepted input strobe to efpga_write_strobe_o/efpga_write_data_o.
// Backpressure: none; non-owner strobes are dropped and counted in a saturating counter.
module config_write_arbiter #(
    parameter int DATA_WIDTH       = 32,
    parameter int IDLE_TIMEOUT     = 1024,
    parameter int JTAG_PRIORITY    = 1,
    parameter int REJECT_CNT_WIDTH = 8
) (
    input  logic                        clk_system_i,
    input  logic                        reset_n_i,
    input  logic [DATA_WIDTH-1:0]       usb_data_i,
    input  logic                        usb_strobe_i,
    input  logic                        usb_boot_i,
    input  logic [DATA_WIDTH-1:0]       jtag_data_i,
    input  logic                        jtag_strobe_i,
    input  logic                        jtag_active_i,
    output logic [DATA_WIDTH-1:0]       efpga_write_data_o,
    output logic                        efpga_write_strobe_o,
    output logic                        efpga_reset_n_o,
    output logic [1:0]                  owner_o,
    output logic [REJECT_CNT_WIDTH-1:0] reject_count_o
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);

    // Encoding doubles as the owner_o code.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_USB  = 2'b01,
        S_JTAG = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic            accept;
    logic            sel_jtag;
    logic            reject;
    logic            usb_req;
    logic            jtag_req;
    logic            own_strobe;
    logic            own_hold;
    logic            other_strobe;

    assign usb_req  = usb_strobe_i | usb_boot_i;
    assign jtag_req = jtag_strobe_i | jtag_active_i;

    // Owner-relative views of the inputs, only meaningful in an OWN state.
    assign own_strobe   = (state == S_JTAG) ? jtag_strobe_i : usb_strobe_i;
    assign own_hold     = (state == S_JTAG) ? jtag_active_i : usb_boot_i;
    assign other_strobe = (state == S_JTAG) ? usb_strobe_i  : jtag_strobe_i;

    // Next state, idle timer, write accept and reject decisions.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        accept    = 1'b0;
        sel_jtag  = 1'b0;
        reject    = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (usb_req && jtag_req) begin
                    // Simultaneous start: loser's strobe this cycle is dropped.
                    if (JTAG_PRIORITY != 0) begin
                        state_nxt = S_JTAG;
                        sel_jtag  = 1'b1;
                        accept    = jtag_strobe_i;
                        reject    = usb_strobe_i;
                    end else begin
                        state_nxt = S_USB;
                        accept    = usb_strobe_i;
                        reject    = jtag_strobe_i;
                    end
                end else if (jtag_req) begin
                    state_nxt = S_JTAG;
                    sel_jtag  = 1'b1;
                    accept    = jtag_strobe_i;
                end else if (usb_req) begin
                    state_nxt = S_USB;
                    accept    = usb_strobe_i;
                end
            end
            S_USB, S_JTAG: begin
                sel_jtag = (state == S_JTAG);
                accept   = own_strobe;
                reject   = other_strobe;
                if (own_strobe || own_hold) begin
                    timer_nxt = '0;
                end else if (timer == TIMER_LAST) begin
                    // Other requester must wait for the next edge from IDLE.
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // State, timer and state-derived outputs; owner/reset track the state register exactly.
    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= S_IDLE;
            timer           <= '0;
            owner_o         <= 2'b00;
            efpga_reset_n_o <= 1'b1;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            owner_o         <= state_nxt;
            efpga_reset_n_o <= (state_nxt == S_IDLE);
        end
    end

    // Registered write path: data loads only on accepted strobes, strobe pulses once per accept.
    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            efpga_write_data_o   <= '0;
            efpga_write_strobe_o <= 1'b0;
        end else begin
            efpga_write_strobe_o <= accept;
            if (accept) begin
                efpga_write_data_o <= sel_jtag ? jtag_data_i : usb_data_i;
            end
        end
    end

    // Saturating count of dropped non-owner strobes; never wraps.
    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            reject_count_o <= '0;
        end else if (reject && (reject_count_o != {REJECT_CNT_WIDTH{1'b1}})) begin
            reject_count_o <= reject_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_config_write_arbiter.sv
// Testbench for config_write_arbiter: directed sessions, contention, timeout and reset.
// Write outputs are checked by a scoreboard monitor; state outputs by direct checks.
// Two instances differ only in JTAG_PRIORITY and share all inputs.
module tb_config_write_arbiter;

    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] dat;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] usb_data;
    logic          usb_strobe;
    logic          usb_boot;
    logic [DW-1:0] jtag_data;
    logic          jtag_strobe;
    logic          jtag_active;

    logic [DW-1:0] wr_data0, wr_data1;
    logic          wr_stb0, wr_stb1;
    logic          frst0, frst1;
    logic [1:0]    owner0, owner1;
    logic [7:0]    rej0, rej1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    config_write_arbiter #(
        .DATA_WIDTH(DW), .IDLE_TIMEOUT(1024), .JTAG_PRIORITY(1), .REJECT_CNT_WIDTH(8)
    ) dut0 (
        .clk_system_i(clk), .reset_n_i(rst_n),
        .usb_data_i(usb_data), .usb_strobe_i(usb_strobe), .usb_boot_i(usb_boot),
        .jtag_data_i(jtag_data), .jtag_strobe_i(jtag_strobe), .jtag_active_i(jtag_active),
        .efpga_write_data_o(wr_data0), .efpga_write_strobe_o(wr_stb0),
        .efpga_reset_n_o(frst0), .owner_o(owner0), .reject_count_o(rej0)
    );

    config_write_arbiter #(
        .DATA_WIDTH(DW), .IDLE_TIMEOUT(1024), .JTAG_PRIORITY(0), .REJECT_CNT_WIDTH(8)
    ) dut1 (
        .clk_system_i(clk), .reset_n_i(rst_n),
        .usb_data_i(usb_data), .usb_strobe_i(usb_strobe), .usb_boot_i(usb_boot),
        .jtag_data_i(jtag_data), .jtag_strobe_i(jtag_strobe), .jtag_active_i(jtag_active),
        .efpga_write_data_o(wr_data1), .efpga_write_strobe_o(wr_stb1),
        .efpga_reset_n_o(frst1), .owner_o(owner1), .reject_count_o(rej1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges so far; at a falling edge, outputs reflect edge number cyc.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // One-cycle USB strobe; when accepted, the word must appear after the next edge.
    task automatic usb_write(input logic [DW-1:0] d, input bit acc);
        usb_strobe = 1'b1;
        usb_data   = d;
        if (acc) sb.push_back('{dat: d, cyc: cyc + 1});
        @(negedge clk);
        usb_strobe = 1'b0;
    endtask

    task automatic jtag_write(input logic [DW-1:0] d, input bit acc);
        jtag_strobe = 1'b1;
        jtag_data   = d;
        if (acc) sb.push_back('{dat: d, cyc: cyc + 1});
        @(negedge clk);
        jtag_strobe = 1'b0;
    endtask

    initial begin
        int e2;
        int h;
        int s2;
        rst_n       = 1'b1;
        usb_data    = '0;
        usb_strobe  = 1'b0;
        usb_boot    = 1'b0;
        jtag_data   = '0;
        jtag_strobe = 1'b0;
        jtag_active = 1'b0;

        // Scoreboard monitor for the priority-1 instance's write port.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_strobe: no strobe for 0x%0h expected at cycle %0d", sb[0].dat, sb[0].cyc);
                    void'(sb.pop_front());
                end
                if (wr_stb0) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: data 0x%0h at cycle %0d, none expected", wr_data0, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_data", 64'(wr_data0), 64'(e.dat));
                        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        join_none

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_owner", 64'(owner0), 64'd0);
        chk("rst_frst", 64'(frst0), 64'd1);
        chk("rst_strobe", 64'(wr_stb0), 64'd0);
        chk("rst_data", 64'(wr_data0), 64'd0);
        chk("rst_reject", 64'(rej0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // USB session: back-to-back writes from IDLE.
        usb_write(32'hDEADBEEF, 1'b1);
        chk("usb_owner", 64'(owner0), 64'd1);
        chk("usb_frst", 64'(frst0), 64'd0);
        usb_write(32'h12345678, 1'b1);
        e2 = cyc;

        // Contention: JTAG strobes dropped while USB owns.
        repeat (3) jtag_write(32'hCAFEF00D, 1'b0);
        chk("rej3_count", 64'(rej0), 64'd3);
        chk("rej3_data", 64'(wr_data0), 64'h12345678);
        chk("rej3_owner", 64'(owner0), 64'd1);

        // Timeout exactly 1024 edges after the last USB strobe.
        wait_until(e2 + 1023);
        chk("usb_pre_close", 64'(owner0), 64'd1);
        @(negedge clk);
        chk("usb_closed", 64'(owner0), 64'd0);
        chk("usb_closed_frst", 64'(frst0), 64'd1);

        // Saturation: USB held via boot level, JTAG strobes rejected.
        usb_boot = 1'b1;
        @(negedge clk);
        chk("boot_owner", 64'(owner0), 64'd1);
        jtag_strobe = 1'b1;
        jtag_data   = 32'hCAFEF00D;
        repeat (252) @(negedge clk);
        jtag_strobe = 1'b0;
        chk("rej_at_max", 64'(rej0), 64'd255);
        jtag_strobe = 1'b1;
        repeat (48) @(negedge clk);
        jtag_strobe = 1'b0;
        chk("rej_saturated", 64'(rej0), 64'd255);

        // Reset mid-session with an output strobe in flight; no clock edge before sampling.
        usb_write_pending: begin
            usb_strobe = 1'b1;
            usb_data   = 32'h0BADF00D;
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            chk("midrst_owner", 64'(owner0), 64'd0);
            chk("midrst_frst", 64'(frst0), 64'd1);
            chk("midrst_strobe", 64'(wr_stb0), 64'd0);
            chk("midrst_reject", 64'(rej0), 64'd0);
            @(negedge clk);
            usb_strobe = 1'b0;
            usb_boot   = 1'b0;
            rst_n      = 1'b1;
            @(negedge clk);
        end

        // Simultaneous start from IDLE.
        usb_strobe  = 1'b1;
        usb_data    = 32'h11111111;
        jtag_data   = 32'h22222222;
        jtag_write(32'h22222222, 1'b1);
        usb_strobe = 1'b0;
        chk("sim_owner_p1", 64'(owner0), 64'd2);
        chk("sim_reject_p1", 64'(rej0), 64'd1);
        chk("sim_owner_p0", 64'(owner1), 64'd1);
        chk("sim_strobe_p0", 64'(wr_stb1), 64'd1);
        chk("sim_data_p0", 64'(wr_data1), 64'h11111111);
        chk("sim_reject_p0", 64'(rej1), 64'd1);

        // Hold line keeps JTAG ownership well past the timeout.
        jtag_active = 1'b1;
        repeat (5000) @(negedge clk);
        chk("hold_owner", 64'(owner0), 64'd2);
        jtag_active = 1'b0;
        h = cyc;

        // Strobe on the terminal-count cycle is accepted and keeps the session.
        wait_until(h + 1023);
        chk("term_pre_owner", 64'(owner0), 64'd2);
        jtag_write(32'hAABBCCDD, 1'b1);
        chk("term_kept_owner", 64'(owner0), 64'd2);
        s2 = cyc;

        // Handover: USB strobe on the close cycle is rejected, granted on the next edge.
        wait_until(s2 + 1023);
        chk("jtag_pre_close", 64'(owner0), 64'd2);
        usb_write(32'h55555555, 1'b0);
        chk("jtag_closed", 64'(owner0), 64'd0);
        chk("close_reject", 64'(rej0), 64'd2);
        usb_write(32'h66666666, 1'b1);
        chk("handover_owner", 64'(owner0), 64'd1);

        repeat (1030) @(negedge clk);
        chk("final_owner", 64'(owner0), 64'd0);
        chk("final_frst", 64'(frst0), 64'd1);
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_write_arbiter.md
Name: config_write_arbiter

Overview:
- Shares the single eFPGA self-write configuration port (32-bit word + strobe) between two requesters: the USB controller and the JTAG TAP.
- Grants the port per session: the first requester to strobe or assert its hold line gets exclusive ownership until it goes idle.
- Holds the fabric in reset while any session is open. Counts writes dropped from the non-owner.
- Sits in top between controller/tap and eFPGA_top. It replaces the ad-hoc `reset_n_i & !boot` gating.

Parameters:
- DATA_WIDTH, 32, width of configuration words.
- IDLE_TIMEOUT, 1024, owner-inactivity cycles before a session closes (must be >= 2).
- JTAG_PRIORITY, 1, if 1 JTAG wins simultaneous session starts, else USB wins.
- REJECT_CNT_WIDTH, 8, width of the saturating reject counter.

Ports:
- clk_system_i  in  1  system/fabric clock; all logic on rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- usb_data_i  in  DATA_WIDTH  USB config word, valid when usb_strobe_i=1.
- usb_strobe_i  in  1  single-cycle write request from USB controller.
- usb_boot_i  in  1  level; USB session requested/held while high.
- jtag_data_i  in  DATA_WIDTH  JTAG config word.
- jtag_strobe_i  in  1  single-cycle write request from JTAG.
- jtag_active_i  in  1  level; JTAG session requested/held while high.
- efpga_write_data_o  out  DATA_WIDTH  registered word to eFPGA SelfWriteData.
- efpga_write_strobe_o  out  1  registered one-cycle strobe to SelfWriteStrobe.
- efpga_reset_n_o  out  1  fabric reset, low while a session is open.
- owner_o  out  2  00 idle, 01 USB, 10 JTAG.
- reject_count_o  out  REJECT_CNT_WIDTH  saturating count of dropped non-owner strobes.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - efpga_write_data_o=0, efpga_write_strobe_o=0, efpga_reset_n_o=1.
  - owner_o=00, reject_count_o=0, idle timer=0.
- States:
  - IDLE: no owner.
  - OWN_USB / OWN_JTAG: exclusive owner.
  - owner_o and efpga_reset_n_o are registered decodes of the state (efpga_reset_n_o=0 iff state≠IDLE).
- Requester "request" = strobe OR hold level (usb_boot_i / jtag_active_i).
- IDLE → OWN_x on the edge where x requests.
  - Both request in the same cycle: JTAG_PRIORITY decides the owner. The loser's strobe that cycle counts as rejected.
- Write path latency is one cycle.
  - Any owner strobe at edge t, including the session-opening strobe accepted from IDLE, gives efpga_write_strobe_o=1 at t+1 with efpga_write_data_o = that word.
  - Data register loads only on accepted strobes and holds otherwise.
  - Strobe output is high for exactly one cycle per accepted input strobe; back-to-back input strobes give back-to-back outputs.
- Non-owner strobe while owned:
  - Dropped; no output strobe.
  - reject_count_o += 1, saturating at all-ones. Never wraps.
  - Cleared only by reset.
- Idle timer:
  - Cleared on each owner strobe and on each cycle the owner's hold level is high.
  - Otherwise increments each cycle in an OWN state.
  - When the timer reaches IDLE_TIMEOUT-1 with no owner activity that cycle, state → IDLE next edge.
  - The session therefore closes exactly IDLE_TIMEOUT cycles after the last owner strobe or hold-high cycle.
  - An owner strobe on the terminal-count cycle is accepted and cancels the close.
- Session handover: closing to IDLE takes one cycle. A request from the other source on the close cycle is not granted until the following edge from IDLE; its strobe on the close cycle counts as rejected.
- In IDLE, the timer is held at 0.
- Timer width: $clog2(IDLE_TIMEOUT+1).
- Reset mid-session: the session aborts immediately, efpga_reset_n_o returns to 1, and any pending output strobe is lost.
- No combinational input→output paths.

Test Plan:
- Reset check: assert reset_n_i low mid-session with state OWN_USB → owner_o=00, efpga_reset_n_o=1, strobe 0, reject_count_o=0 with no clock edge.
- USB session: USB strobes 0xDEADBEEF then 0x12345678 on consecutive cycles from IDLE → outputs strobe on cycles t+1 and t+2 with those words, owner_o=01, efpga_reset_n_o=0.
- USB session timeout: after the USB strobes above, no further activity → IDLE exactly 1024 cycles after the last strobe, efpga_reset_n_o=1.
- Contention: in OWN_USB, jtag_strobe_i with 0xCAFEF00D ×3 → no output strobe, data unchanged, reject_count_o=3; drive 300 rejects → saturates at 255.
- Simultaneous start: both strobe in IDLE at the same edge, JTAG_PRIORITY=1 → owner_o=10, JTAG word output, reject_count_o=1. Repeat with JTAG_PRIORITY=0 → owner_o=01.
- Hold line: jtag_active_i high 5000 cycles with no strobes → session stays OWN_JTAG. After the fall → IDLE 1024 cycles later. A JTAG strobe at terminal count keeps the session open and outputs the word.
